clock_gate_ctrl: RTL and testbench



---
 rtl/clock_gate_ctrl.sv | 172 +++++++++++++++++
 tb/tb_clock_gate_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gate_ctrl.sv
// Request-side controller for the matrix clock gate: counts pending jobs,
// requests the gated clock on when work arrives and off after an idle hold-off.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES  = 8,
  parameter int WAKE_TIMEOUT = 16,
  parameter int CNT_W        = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             req_i,
  input  logic             done_i,
  input  logic             start_ack_i,
  output logic             clk_en_o,
  output logic             clk_end_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] pending_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAKE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_SLEEP = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};
  localparam logic [7:0]       IDLE_LOAD = 8'(IDLE_CYCLES);
  localparam logic [7:0]       WAKE_LAST = 8'(WAKE_TIMEOUT - 1);

  state_t           state_r;
  logic [CNT_W-1:0] pending_r;
  logic [CNT_W-1:0] pend_next_s;
  logic [7:0]       idle_cnt_r;
  logic [7:0]       wake_cnt_r;
  logic             clk_en_r;
  logic             clk_end_r;
  logic             busy_r;
  logic             timeout_r;

  // Next pending count: saturating up on req, floored down on done, hold on both.
  always_comb begin
    pend_next_s = pending_r;
    if (req_i && !done_i) begin
      if (pending_r != PEND_MAX) begin
        pend_next_s = pending_r + PEND_ONE;
      end else begin
        pend_next_s = pending_r;
      end
    end else if (done_i && !req_i) begin
      if (pending_r != PEND_ZERO) begin
        pend_next_s = pending_r - PEND_ONE;
      end else begin
        pend_next_s = pending_r;
      end
    end else begin
      pend_next_s = pending_r;
    end
  end

  // Control FSM with registered pulse, busy, timeout and pending outputs.
  always_ff @(posedge clk_i or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      pending_r  <= PEND_ZERO;
      idle_cnt_r <= 8'd0;
      wake_cnt_r <= 8'd0;
      clk_en_r   <= 1'b0;
      clk_end_r  <= 1'b0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      pending_r <= pend_next_s;
      clk_en_r  <= 1'b0;
      clk_end_r <= 1'b0;
      if (req_i) begin
        timeout_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          wake_cnt_r <= 8'd0;
          // Hold off one cycle after a clk_end so the two requests never abut.
          if ((pend_next_s != PEND_ZERO) && !clk_end_r) begin
            state_r  <= ST_WAKE;
            clk_en_r <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_WAKE: begin
          if (start_ack_i) begin
            state_r    <= ST_RUN;
            wake_cnt_r <= 8'd0;
          end else if ((wake_cnt_r >= WAKE_LAST) && !clk_en_r) begin
            state_r    <= ST_IDLE;
            wake_cnt_r <= 8'd0;
            timeout_r  <= 1'b1;
            clk_end_r  <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            wake_cnt_r <= wake_cnt_r + 8'd1;
          end
        end
        ST_RUN: begin
          if (pend_next_s == PEND_ZERO) begin
            state_r    <= ST_HOLD;
            idle_cnt_r <= IDLE_LOAD;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_HOLD: begin
          if (pend_next_s != PEND_ZERO) begin
            state_r <= ST_RUN;
          end else if (idle_cnt_r == 8'd0) begin
            state_r   <= ST_SLEEP;
            clk_end_r <= 1'b1;
          end else begin
            idle_cnt_r <= idle_cnt_r - 8'd1;
          end
        end
        ST_SLEEP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy_r     <= 1'b0;
          idle_cnt_r <= 8'd0;
          wake_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  assign clk_en_o  = clk_en_r;
  assign clk_end_o = clk_end_r;
  assign busy_o    = busy_r;
  assign timeout_o = timeout_r;
  assign pending_o = pending_r;

  clock_gate_ctrl_checker u_checker (
    .clk_i   (clk_i),
    .rst     (rst),
    .clk_en  (clk_en_r),
    .clk_end (clk_end_r)
  );

endmodule

// Pulse-shape properties of the clock on/off request outputs.
module clock_gate_ctrl_checker (
  input logic clk_i,
  input logic rst,
  input logic clk_en,
  input logic clk_end
);

  a_never_both: assert property (@(posedge clk_i) disable iff (!rst)
    !(clk_en && clk_end));

  a_en_gap: assert property (@(posedge clk_i) disable iff (!rst)
    clk_en |=> (!clk_en && !clk_end));

  a_end_gap: assert property (@(posedge clk_i) disable iff (!rst)
    clk_end |=> (!clk_en && !clk_end));

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl: a timeline model predicts every output
// each cycle, with literal checks pinning the key latencies.
module tb_clock_gate_ctrl;

  localparam int IDLE_C = 8;
  localparam int WAKE_T = 16;
  localparam int CW     = 4;
  localparam int PMAX   = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0;
  logic          done_i = 1'b0;
  logic          start_ack_i = 1'b0;
  logic          clk_en_o;
  logic          clk_end_o;
  logic          busy_o;
  logic          timeout_o;
  logic [CW-1:0] pending_o;

  clock_gate_ctrl #(.IDLE_CYCLES(IDLE_C), .WAKE_TIMEOUT(WAKE_T), .CNT_W(CW)) dut (
    .clk_i       (clk_i),
    .rst         (rst),
    .req_i       (req_i),
    .done_i      (done_i),
    .start_ack_i (start_ack_i),
    .clk_en_o    (clk_en_o),
    .clk_end_o   (clk_end_o),
    .busy_o      (busy_o),
    .timeout_o   (timeout_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int now = 0;

  // Model: gate on/off timeline expressed as absolute cycle numbers.
  int m_pend, m_wake_t, m_drain_t, m_end_t;
  bit m_on, m_acked, m_tout, m_end_to;
  bit e_en, e_end, e_busy, e_tout;
  int e_pend;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, now, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_on = 0; m_acked = 0; m_tout = 0; m_end_to = 0;
    m_wake_t = 0; m_drain_t = -1; m_end_t = -100;
  endtask

  task automatic model_step(input bit r, input bit d, input bit a);
    int n;
    n = now;
    e_en = 0;
    e_end = 0;
    if (r && !d) begin
      if (m_pend < PMAX) m_pend++;
    end else if (d && !r) begin
      if (m_pend > 0) m_pend--;
    end
    if (r) m_tout = 0;
    if (!m_on) begin
      if (m_pend > 0 && m_end_t != n) begin
        e_en = 1; m_on = 1; m_acked = 0; m_wake_t = n + 1; m_drain_t = -1;
      end
    end else if (!m_acked) begin
      if (a) m_acked = 1;
      else if (n >= m_wake_t + WAKE_T - 1) begin
        e_end = 1; m_on = 0; m_tout = 1; m_end_t = n + 1; m_end_to = 1;
      end
    end else if (m_drain_t < 0) begin
      if (m_pend == 0) m_drain_t = n + 1;
    end else begin
      if (m_pend > 0) m_drain_t = -1;
      else if (n == m_drain_t + IDLE_C) begin
        e_end = 1; m_on = 0; m_end_t = n + 1; m_end_to = 0;
      end
    end
    e_busy = m_on || (e_end && !m_end_to);
    e_tout = m_tout;
    e_pend = m_pend;
  endtask

  task automatic cyc(input bit r, input bit d, input bit a);
    req_i = r; done_i = d; start_ack_i = a;
    model_step(r, d, a);
    @(posedge clk_i);
    #1;
    now++;
    chk("clk_en", int'(clk_en_o), int'(e_en));
    chk("clk_end", int'(clk_end_o), int'(e_end));
    chk("busy", int'(busy_o), int'(e_busy));
    chk("timeout", int'(timeout_o), int'(e_tout));
    chk("pending", int'(pending_o), e_pend);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"}, int'(clk_en_o), 0);
    chk({tag, "_end"}, int'(clk_end_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_tout"}, int'(timeout_o), 0);
    chk({tag, "_pend"}, int'(pending_o), 0);
  endtask

  initial begin
    model_reset();
    #3;
    chk_all_zero("reset");
    @(posedge clk_i); @(posedge clk_i); #1;
    rst = 1'b1;

    // Single job: req@0, ack@3, done@10 -> clk_end@20, idle@21
    cyc(1, 0, 0);
    chk("s1_en_c1", int'(clk_en_o), 1);
    chk("s1_pend_c1", int'(pending_o), 1);
    idle(2);
    cyc(0, 0, 1);
    idle(6);
    cyc(0, 1, 0);
    idle(9);
    chk("s1_end_c20", int'(clk_end_o), 1);
    chk("s1_model_end_c20", int'(e_end), 1);
    idle(1);
    chk("s1_busy_c21", int'(busy_o), 0);
    cyc(0, 0, 1);   // ack outside WAKE is ignored
    idle(1);

    // Burst of three requests -> one clk_en, pending 3
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("burst_pend", int'(pending_o), 3);
    cyc(0, 0, 1);
    idle(2);
    cyc(0, 1, 0); idle(1);
    cyc(0, 1, 0); idle(1);
    chk("burst_pend_1", int'(pending_o), 1);
    cyc(0, 1, 0);
    idle(9);
    chk("burst_end", int'(clk_end_o), 1);
    idle(2);

    // Re-request four cycles after the last done
    cyc(1, 0, 0); idle(1);
    cyc(0, 0, 1); idle(2);
    cyc(0, 1, 0);
    idle(3);
    cyc(1, 0, 0);
    chk("hold_no_en", int'(clk_en_o), 0);
    chk("hold_no_end", int'(clk_end_o), 0);
    chk("hold_pend", int'(pending_o), 1);
    chk("hold_busy", int'(busy_o), 1);
    idle(12);
    cyc(0, 1, 0);
    idle(11);

    // Simultaneous req+done at pending 2, done at pending 0
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 1, 0);
    chk("sim_pend", int'(pending_o), 2);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("under_pend", int'(pending_o), 0);
    idle(8);
    chk("sim_end", int'(clk_end_o), 1);
    idle(2);

    // Wake timeout, retry, late ack, timeout cleared by next req
    cyc(1, 0, 0);
    idle(16);
    chk("to_flag", int'(timeout_o), 1);
    chk("to_end", int'(clk_end_o), 1);
    idle(1);
    chk("to_no_en_c18", int'(clk_en_o), 0);
    idle(1);
    chk("to_retry_en", int'(clk_en_o), 1);
    cyc(0, 0, 1);
    chk("to_sticky", int'(timeout_o), 1);
    cyc(0, 1, 0);
    idle(3);
    cyc(1, 0, 0);
    chk("to_cleared", int'(timeout_o), 0);
    cyc(0, 1, 0);
    idle(11);

    // Saturation at 15, then drain to 2 for the mid-run reset
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    for (int i = 0; i < 14; i++) cyc(1, 0, 0);
    chk("sat_pend", int'(pending_o), PMAX);
    for (int i = 0; i < 13; i++) cyc(0, 1, 0);
    chk("pre_rst_pend", int'(pending_o), 2);
    chk("pre_rst_busy", int'(busy_o), 1);

    // Asynchronous reset mid-RUN
    req_i = 1'b0; done_i = 1'b0; start_ack_i = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk_i); #1;
    chk("midrst_no_end", int'(clk_end_o), 0);
    rst = 1'b1;
    model_reset();
    cyc(1, 0, 0);
    chk("post_rst_en", int'(clk_en_o), 1);
    chk("post_rst_pend", int'(pending_o), 1);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    idle(11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
